// File: rtl/result_tx.sv
// result_tx
//   Transmit side of the Raspberry Pi GPIO byte link. Snapshots the classifier
//   result (winning class + per-class signed scores) on an accepted start and
//   sends it as a fixed byte frame on an 8-bit bus. A 4-phase valid/ack
//   handshake paces each byte, and the Pi drives the ack.
//
//   Frame: HEADER, {4'b0, class_idx}, score[0] .. score[NUM_CLASSES-1]
//          [, XOR checksum of all preceding bytes when RESULT_TX_CHECKSUM_EN]
//
//   Build option: define RESULT_TX_CHECKSUM_EN to append the checksum byte.
//
//   Ports:
//     pi_clk      in   clock
//     rst         in   synchronous active-high reset
//     start       in   one-cycle pulse, result ready (accepted only in IDLE)
//     class_idx   in   [3:0] winning class, sampled on accepted start
//     scores_flat in   [NUM_CLASSES*8-1:0] packed signed scores, score k at [8k+7:8k]
//     pi_ack      in   Pi acknowledge (asynchronous, synchronized internally)
//     gpio_out    out  [7:0] byte to the Pi
//     gpio_valid  out  gpio_out is stable and may be read
//     busy        out  frame in progress
//     done        out  one-cycle pulse after the last byte's handshake completes
module result_tx #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     pi_clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [3:0]               class_idx,
    input  logic [NUM_CLASSES*8-1:0] scores_flat,
    input  logic                     pi_ack,
    output logic [7:0]               gpio_out,
    output logic                     gpio_valid,
    output logic                     busy,
    output logic                     done
);

`ifdef RESULT_TX_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = NUM_CLASSES + 3;
`else
    localparam int unsigned FRAME_LEN = NUM_CLASSES + 2;
`endif
    localparam int unsigned IDX_W = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_SEND,
        S_WAIT_LOW
    } state_t;

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic [3:0]               snap_class;
    logic [NUM_CLASSES*8-1:0] snap_scores;
    logic [SYNC_STAGES-1:0]   ack_sync;
    logic                     ack_s;
    logic [IDX_W-1:0]         load_idx;
    logic [7:0]               load_byte;
`ifdef RESULT_TX_CHECKSUM_EN
    logic [7:0]               csum;
`endif

    // pi_ack is asynchronous; only the last stage is used for decisions.
    always_ff @(posedge pi_clk) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], pi_ack};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // Byte about to be loaded into gpio_out: the current index when leaving
    // ARM, the next index when leaving WAIT_LOW.
    always_comb begin
        load_idx  = (state == S_WAIT_LOW) ? idx + IDX_W'(1) : idx;
        load_byte = '0;
        if (load_idx == '0) begin
            load_byte = HEADER;
        end else if (load_idx == IDX_W'(1)) begin
            load_byte = {4'b0000, snap_class};
        end
        for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
            if (load_idx == IDX_W'(k + 2)) begin
                load_byte = snap_scores[8*k +: 8];
            end
        end
`ifdef RESULT_TX_CHECKSUM_EN
        if (load_idx == IDX_W'(NUM_CLASSES + 2)) begin
            load_byte = csum;
        end
`endif
    end

    always_ff @(posedge pi_clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            snap_class  <= '0;
            snap_scores <= '0;
            gpio_out    <= '0;
            gpio_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        snap_class  <= class_idx;
                        snap_scores <= scores_flat;
                        idx         <= '0;
                        busy        <= 1'b1;
                        if (!ack_s) begin
                            // Header is constant, so it can go out on the
                            // same edge the snapshot is taken.
                            gpio_out   <= HEADER;
                            gpio_valid <= 1'b1;
                            state      <= S_SEND;
`ifdef RESULT_TX_CHECKSUM_EN
                            csum       <= HEADER;
`endif
                        end else begin
                            state <= S_ARM;
`ifdef RESULT_TX_CHECKSUM_EN
                            csum  <= '0;
`endif
                        end
                    end
                end
                S_ARM: begin
                    // A stale-high ack must fall before the header is offered.
                    if (!ack_s) begin
                        gpio_out   <= load_byte;
                        gpio_valid <= 1'b1;
                        state      <= S_SEND;
`ifdef RESULT_TX_CHECKSUM_EN
                        csum       <= csum ^ load_byte;
`endif
                    end
                end
                S_SEND: begin
                    if (ack_s) begin
                        gpio_valid <= 1'b0;
                        state      <= S_WAIT_LOW;
                    end
                end
                S_WAIT_LOW: begin
                    if (!ack_s) begin
                        if (idx == IDX_W'(FRAME_LEN - 1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            idx        <= load_idx;
                            gpio_out   <= load_byte;
                            gpio_valid <= 1'b1;
                            state      <= S_SEND;
`ifdef RESULT_TX_CHECKSUM_EN
                            csum       <= csum ^ load_byte;
`endif
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_tx.sv
// tb_result_tx
//   Directed bench for result_tx. A Pi model handshakes each byte and checks
//   value, stability while valid, and that valid drops after ack. Expected
//   frames are built from the stimulus values inside the bench.
module tb_result_tx;

    localparam int unsigned NUM_CLASSES = 10;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = NUM_CLASSES + 3;
`else
    localparam int unsigned FRAME_LEN = NUM_CLASSES + 2;
`endif

    logic                     pi_clk;
    logic                     rst;
    logic                     start;
    logic [3:0]               class_idx;
    logic [NUM_CLASSES*8-1:0] scores_flat;
    logic                     pi_ack;
    logic [7:0]               gpio_out;
    logic                     gpio_valid;
    logic                     busy;
    logic                     done;

    int unsigned checks;
    int unsigned failures;
    int unsigned done_cnt;
    logic [7:0]  exp_frame [FRAME_LEN];

    result_tx #(
        .NUM_CLASSES(NUM_CLASSES),
        .HEADER     (8'hA5),
        .SYNC_STAGES(2)
    ) dut (
        .pi_clk     (pi_clk),
        .rst        (rst),
        .start      (start),
        .class_idx  (class_idx),
        .scores_flat(scores_flat),
        .pi_ack     (pi_ack),
        .gpio_out   (gpio_out),
        .gpio_valid (gpio_valid),
        .busy       (busy),
        .done       (done)
    );

    initial pi_clk = 1'b0;
    always #5 pi_clk = ~pi_clk;

    always @(negedge pi_clk) begin
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_frame(input logic [3:0] c, input logic [NUM_CLASSES*8-1:0] s);
        logic [7:0] x;
        exp_frame[0] = 8'hA5;
        exp_frame[1] = {4'b0000, c};
        for (int unsigned k = 0; k < NUM_CLASSES; k++) exp_frame[k+2] = s[8*k +: 8];
`ifdef RESULT_TX_CHECKSUM_EN
        x = 8'h00;
        for (int unsigned k = 0; k < NUM_CLASSES + 2; k++) x = x ^ exp_frame[k];
        exp_frame[NUM_CLASSES+2] = x;
`else
        x = 8'h00;
`endif
    endtask

    // One Pi read: wait for valid, check byte, ack for 'hold' cycles, release,
    // and return once valid has been seen low.
    task automatic pi_byte(input logic [7:0] exp, input int unsigned hold, input string tag);
        int unsigned n;
        bit stable;
        bit dropped;
        n = 0;
        while (gpio_valid !== 1'b1 && n < 100) begin
            @(negedge pi_clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, gpio_valid}, 32'd1);
        chk(tag, {24'd0, gpio_out}, {24'd0, exp});
        stable  = 1'b1;
        dropped = 1'b0;
        @(negedge pi_clk);
        if (gpio_valid !== 1'b1 || gpio_out !== exp) stable = 1'b0;
        pi_ack = 1'b1;
        for (int unsigned k = 0; k < hold; k++) begin
            @(negedge pi_clk);
            if (gpio_valid === 1'b1) begin
                if (gpio_out !== exp) stable = 1'b0;
            end else begin
                dropped = 1'b1;
            end
        end
        pi_ack = 1'b0;
        n = 0;
        while (!dropped && n < 20) begin
            @(negedge pi_clk);
            n++;
            if (gpio_valid === 1'b1) begin
                if (gpio_out !== exp) stable = 1'b0;
            end else begin
                dropped = 1'b1;
            end
        end
        chk({tag, "_stable"}, {31'd0, stable}, 32'd1);
        chk({tag, "_drop"}, {31'd0, dropped}, 32'd1);
    endtask

    task automatic pulse_start(input logic [3:0] c, input logic [NUM_CLASSES*8-1:0] s);
        class_idx   = c;
        scores_flat = s;
        start       = 1'b1;
        @(negedge pi_clk);
        start = 1'b0;
    endtask

    initial begin
        logic [NUM_CLASSES*8-1:0] s;
        bit idle_ok;
        int unsigned d0;
        int unsigned n;

        checks = 0; failures = 0; done_cnt = 0;
        rst = 1'b1; start = 1'b0; class_idx = '0; scores_flat = '0; pi_ack = 1'b0;

        // Reset then idle with random ack activity.
        @(negedge pi_clk);
        @(negedge pi_clk);
        rst = 1'b0;
        chk("rst_gpio_out", {24'd0, gpio_out}, 32'h00);
        chk("rst_valid", {31'd0, gpio_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        idle_ok = 1'b1;
        for (int i = 0; i < 24; i++) begin
            pi_ack = 1'($urandom_range(0, 1));
            @(negedge pi_clk);
            if (gpio_valid !== 1'b0 || busy !== 1'b0 || gpio_out !== 8'h00) idle_ok = 1'b0;
        end
        pi_ack = 1'b0;
        repeat (3) @(negedge pi_clk);
        chk("idle_ack_no_effect", {31'd0, idle_ok}, 32'd1);
        chk("idle_no_done", done_cnt, 32'd0);

        // Basic frame: class 7, score[7]=0x40, hand-computed bytes.
        for (int unsigned k = 0; k < FRAME_LEN; k++) exp_frame[k] = 8'h00;
        exp_frame[0] = 8'hA5;
        exp_frame[1] = 8'h07;
        exp_frame[9] = 8'h40;
`ifdef RESULT_TX_CHECKSUM_EN
        exp_frame[12] = 8'hE2;
`endif
        s = '0;
        s[8*7 +: 8] = 8'h40;
        d0 = done_cnt;
        pulse_start(4'd7, s);
        chk("lat_valid", {31'd0, gpio_valid}, 32'd1);
        chk("lat_header", {24'd0, gpio_out}, 32'hA5);
        chk("lat_busy", {31'd0, busy}, 32'd1);
        for (int unsigned k = 0; k < FRAME_LEN; k++) begin
            pi_byte(exp_frame[k], 4, $sformatf("basic_b%0d", k));
            if (k < FRAME_LEN - 1) chk($sformatf("basic_busy%0d", k), {31'd0, busy}, 32'd1);
        end
        // ack released at this negedge: done appears 3 edges later, and a
        // start sampled on that same edge must be ignored.
        @(negedge pi_clk);
        chk("basic_no_early_done", done_cnt - d0, 32'd0);
        @(negedge pi_clk);
        start = 1'b1;
        @(negedge pi_clk);
        start = 1'b0;
        chk("basic_done_pulse", {31'd0, done}, 32'd1);
        chk("basic_done_busy", {31'd0, busy}, 32'd0);
        @(negedge pi_clk);
        chk("done_cycle_start_ignored_busy", {31'd0, busy}, 32'd0);
        chk("done_cycle_start_ignored_valid", {31'd0, gpio_valid}, 32'd0);
        repeat (4) @(negedge pi_clk);
        chk("basic_done_once", done_cnt - d0, 32'd1);

        // Stale ack at start, then a second start mid-frame with new data.
        s = '0;
        for (int unsigned k = 0; k < NUM_CLASSES; k++) s[8*k +: 8] = 8'(8'h11 * (k + 1));
        build_frame(4'd3, s);
        pi_ack = 1'b1;
        repeat (4) @(negedge pi_clk);
        pulse_start(4'd3, s);
        class_idx   = 4'd9;
        scores_flat = '1;
        chk("arm_busy", {31'd0, busy}, 32'd1);
        chk("arm_valid", {31'd0, gpio_valid}, 32'd0);
        repeat (6) @(negedge pi_clk);
        chk("arm_still_waiting", {31'd0, gpio_valid}, 32'd0);
        pi_ack = 1'b0;
        d0 = done_cnt;
        for (int unsigned k = 0; k < FRAME_LEN; k++) begin
            if (k == 3) pulse_start(4'd9, '1);
            pi_byte(exp_frame[k], 3, $sformatf("stale_b%0d", k));
        end
        repeat (6) @(negedge pi_clk);
        chk("stale_done_once", done_cnt - d0, 32'd1);
        chk("stale_no_requeue_busy", {31'd0, busy}, 32'd0);
        chk("stale_no_requeue_valid", {31'd0, gpio_valid}, 32'd0);

        // Reset during SEND of byte 5.
        s = '0;
        for (int unsigned k = 0; k < NUM_CLASSES; k++) s[8*k +: 8] = 8'(8'h20 + k);
        build_frame(4'd5, s);
        d0 = done_cnt;
        pulse_start(4'd5, s);
        for (int unsigned k = 0; k < 5; k++) pi_byte(exp_frame[k], 3, $sformatf("rstmid_b%0d", k));
        n = 0;
        while (gpio_valid !== 1'b1 && n < 100) begin
            @(negedge pi_clk);
            n++;
        end
        chk("rstmid_b5", {24'd0, gpio_out}, {24'd0, exp_frame[5]});
        rst = 1'b1;
        @(negedge pi_clk);
        rst = 1'b0;
        chk("rstmid_valid", {31'd0, gpio_valid}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge pi_clk);
        chk("rstmid_no_done", done_cnt - d0, 32'd0);
        pulse_start(4'd5, s);
        chk("rstmid_restart_header", {24'd0, gpio_out}, 32'hA5);
        for (int unsigned k = 0; k < FRAME_LEN; k++) pi_byte(exp_frame[k], 3, $sformatf("rstre_b%0d", k));
        repeat (5) @(negedge pi_clk);
        chk("rstre_done_once", done_cnt - d0, 32'd1);

        // Slow/fast Pi with negative scores.
        s = {10{8'h01}};
        s[8*0 +: 8] = 8'h80;
        s[8*1 +: 8] = 8'hFF;
        s[8*2 +: 8] = 8'h7F;
        s[8*9 +: 8] = 8'h81;
        build_frame(4'hC, s);
        d0 = done_cnt;
        pulse_start(4'hC, s);
        for (int unsigned k = 0; k < FRAME_LEN; k++)
            pi_byte(exp_frame[k], (k % 2 == 0) ? 1 : 20, $sformatf("neg_b%0d", k));
        repeat (6) @(negedge pi_clk);
        chk("neg_done_once", done_cnt - d0, 32'd1);
        chk("neg_busy_end", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_tx.md
Name: result_tx

Overview:
- Transmit direction of the Raspberry Pi GPIO byte link. The image loader receives pixels from the Pi; this block returns the inference result to the Pi.
- Snapshots the classifier output: the winning class index and the per-class signed scores.
- Sends them as a fixed byte frame on an 8-bit GPIO output bus.
- Each byte is paced by a 4-phase valid/ack handshake driven by the Pi.

Parameters:
- NUM_CLASSES, 10, number of score bytes in the frame.
- HEADER, 8'hA5, first byte of every frame.
- SYNC_STAGES, 2, flop stages on pi_ack before use (minimum 2).

Ports:
- pi_clk  in  1  sole clock for the block.
- rst  in  1  reset. Synchronous, active-high.
- start  in  1  one-cycle pulse from the inference core: result is ready.
- class_idx  in  4  winning class, sampled on an accepted start.
- scores_flat  in  NUM_CLASSES*8  packed signed scores. Score k occupies bits [8k+7:8k]. Sampled on an accepted start.
- pi_ack  in  1  Pi acknowledge, asynchronous to pi_clk.
- gpio_out  out  8  byte driven to the Pi.
- gpio_valid  out  1  gpio_out is stable and may be read.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse when the last byte's handshake completes.

Behaviour:
- Reset values: gpio_out=0, gpio_valid=0, busy=0, done=0. FSM goes to IDLE, byte index=0, snapshot registers=0, sync flops=0.
- rst asserted mid-frame aborts the frame immediately. No done pulse is produced.
- pi_ack passes through SYNC_STAGES flops; the synchronized signal is ack_s. All handshake decisions use ack_s only.
- Frame byte order:
  - index 0: HEADER.
  - index 1: {4'b0, class_idx}.
  - index 2..NUM_CLASSES+1: score[0]..score[NUM_CLASSES-1].
  - optional checksum (see Optional Feature).
- FRAME_LEN = NUM_CLASSES+2 = 12 without checksum, 13 with checksum.
- IDLE:
  - busy=0, gpio_valid=0.
  - start=1 latches class_idx and scores_flat, sets index=0, busy=1.
  - Next state is SEND if ack_s=0, else ARM.
- ARM: wait until ack_s=0, then go to SEND. This prevents a stale-high ack from consuming the header.
- SEND:
  - gpio_out=byte[index], gpio_valid=1.
  - gpio_out is registered and changes only on entry to SEND, never while gpio_valid=1.
  - ack_s=1 causes gpio_valid=0 on the next cycle and a transition to WAIT_LOW.
- WAIT_LOW: on ack_s=0:
  - if index==FRAME_LEN-1: pulse done for 1 cycle, busy=0, go to IDLE.
  - otherwise: index+1, go to SEND.
- Latency: start at cycle t gives gpio_valid=1 with gpio_out=HEADER at cycle t+1, provided ack_s=0 at t.
- start while busy=1 is ignored. The snapshot is unchanged and no queueing occurs.
- start on the same cycle as done's IDLE return is also ignored. A new start is accepted only when the FSM is in IDLE.
- Sampled inputs may change after start without affecting the frame in flight.
- Scores are transmitted as raw two's-complement bytes with no sign manipulation.
- pi_ack activity while in IDLE has no effect on any output.

Optional Feature:
- Macro: RESULT_TX_CHECKSUM_EN.
- Defined:
  - One extra byte at index NUM_CLASSES+2.
  - Value = XOR of all preceding frame bytes (header, class byte, all scores).
  - FRAME_LEN = NUM_CLASSES+3.
  - The checksum is accumulated while bytes are sent; no extra cycles are inserted before the checksum's SEND.
- Undefined: no checksum byte, no accumulator logic; FRAME_LEN = NUM_CLASSES+2.

Test Plan:
- Reset then idle: rst high 2 cycles, pi_ack toggled randomly in IDLE -> gpio_out=0x00, gpio_valid=0, busy=0, done never pulses.
- Basic frame (checksum off):
  - Stimulus: class_idx=7, score[7]=0x40, other scores 0x00, start pulse, Pi acks each byte.
  - Response: 12 bytes A5,07,00,00,00,00,00,00,00,40,00,00; done pulses once after the 12th ack falls.
- Checksum on:
  - Stimulus: same as the basic frame.
  - Response: 13 bytes; last byte 0xE2 (A5^07^40); busy stays 1 until done.
- Stale ack / busy start:
  - Stimulus: pi_ack held high when start arrives; a second start issued with new data mid-frame.
  - Response: FSM waits in ARM until ack falls; the header is sent only after that; the frame carries only the first snapshot.
- Reset mid-frame:
  - Stimulus: rst asserted during SEND of byte 5.
  - Response: next cycle gpio_valid=0, busy=0, no done; a subsequent start sends a full frame from HEADER.
- Slow/fast Pi:
  - Stimulus: ack high for 1 cycle vs 20 cycles, negative scores 0x80 and 0xFF.
  - Response: gpio_out stable throughout every valid window; bytes 0x80 and 0xFF transmitted unchanged.
